// File: rtl/msi_sched_pkg.sv
// rtl/msi_sched_pkg.sv - shared constants and FSM encoding for the MSI scheduler
package msi_sched_pkg;

  localparam int VEC_W       = 8;
  localparam int MAX_INT_NUM = 32;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ARB  = 4'b0010,
    ST_REQ  = 4'b0100,
    ST_HOLD = 4'b1000
  } state_t;

endpackage

// File: rtl/msi_sched_if.sv
// rtl/msi_sched_if.sv - endpoint core cfg_interrupt handshake (MSI mode)
interface msi_sched_if;
  import msi_sched_pkg::*;

  logic             cfg_interrupt_n;
  logic             cfg_interrupt_rdy_n;
  logic             cfg_interrupt_assert_n;
  logic [VEC_W-1:0] cfg_interrupt_di;

  modport master (
    output cfg_interrupt_n,
    output cfg_interrupt_assert_n,
    output cfg_interrupt_di,
    input  cfg_interrupt_rdy_n
  );

  modport slave (
    input  cfg_interrupt_n,
    input  cfg_interrupt_assert_n,
    input  cfg_interrupt_di,
    output cfg_interrupt_rdy_n
  );

endinterface

// File: rtl/msi_sched_rr_pick.sv
// rtl/msi_sched_rr_pick.sv - combinational round-robin picker, first request after last_grant
module rr_pick #(
  parameter int C_INT_NUM = 4,
  parameter int IDX_W     = (C_INT_NUM > 1) ? $clog2(C_INT_NUM) : 1
) (
  input  logic [C_INT_NUM-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  int j;

  // Scan from farthest to nearest so the nearest request after last_grant wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = C_INT_NUM; k >= 1; k--) begin
      j = (int'(last_grant) + k) % C_INT_NUM;
      if (req[j[IDX_W-1:0]]) begin
        idx   = j[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msi_sched.sv
// rtl/msi_sched.sv - round-robin MSI scheduler with hold-off; MSI_SCHED_STATS_EN adds sent/coalesced counters
module msi_sched
  import msi_sched_pkg::*;
#(
  parameter int C_INT_NUM  = 4,
  parameter int C_VEC_BASE = 0,
  parameter int C_HOLD_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [C_INT_NUM-1:0] int_src,
  input  logic [C_INT_NUM-1:0] int_mask,
  input  logic                 msi_enable,
  input  logic [C_HOLD_W-1:0]  holdoff_cycles,
  msi_sched_if.master          cfg,
  output logic [C_INT_NUM-1:0] int_pending
`ifdef MSI_SCHED_STATS_EN
  ,
  output logic [31:0]          msi_sent_cnt,
  output logic [31:0]          msi_coal_cnt
`endif
);

  localparam int IDX_W = (C_INT_NUM > 1) ? $clog2(C_INT_NUM) : 1;

  state_t               state, state_nxt;
  logic [C_INT_NUM-1:0] int_src_d, pending, evt, eligible, clr;
  logic [IDX_W-1:0]     sel, last_grant, pick_idx;
  logic                 pick_valid, accept, issue;
  logic [C_HOLD_W-1:0]  hold_cnt;
  logic                 irq_n;
  logic [VEC_W-1:0]     vec;

  assign evt      = int_src & ~int_src_d;
  assign eligible = msi_enable ? (pending & ~int_mask) : '0;
  assign accept   = (state == ST_REQ) && !cfg.cfg_interrupt_rdy_n;
  assign clr      = accept ? (C_INT_NUM'(1) << sel) : '0;

  rr_pick #(.C_INT_NUM(C_INT_NUM), .IDX_W(IDX_W)) u_pick (
    .req        (eligible),
    .last_grant (last_grant),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  // Once REQ is entered the handshake always completes, regardless of mask/enable.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: if (|eligible) state_nxt = ST_ARB;
      ST_ARB: begin
        if (pick_valid) begin
          state_nxt = ST_REQ;
          issue     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ:  if (accept) state_nxt = (holdoff_cycles != '0) ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (hold_cnt <= C_HOLD_W'(1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      int_src_d  <= '0;
      pending    <= '0;
      sel        <= '0;
      last_grant <= IDX_W'(C_INT_NUM - 1);
      hold_cnt   <= '0;
      irq_n      <= 1'b1;
      vec        <= '0;
    end else begin
      state     <= state_nxt;
      int_src_d <= int_src;
      // A new event on a bit being cleared this cycle keeps it pending.
      pending   <= (pending & ~clr) | evt;
      if (issue) begin
        sel   <= pick_idx;
        vec   <= VEC_W'(C_VEC_BASE + int'(pick_idx));
        irq_n <= 1'b0;
      end
      if (accept) begin
        last_grant <= sel;
        irq_n      <= 1'b1;
        hold_cnt   <= holdoff_cycles;
      end else if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt - C_HOLD_W'(1);
      end
    end
  end

`ifdef MSI_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      msi_sent_cnt <= '0;
      msi_coal_cnt <= '0;
    end else begin
      if (accept) msi_sent_cnt <= msi_sent_cnt + 32'd1;
      if (|(evt & pending)) msi_coal_cnt <= msi_coal_cnt + 32'd1;
    end
  end
`endif

  assign cfg.cfg_interrupt_n        = irq_n;
  assign cfg.cfg_interrupt_assert_n = 1'b0;
  assign cfg.cfg_interrupt_di       = vec;
  assign int_pending                = pending;

endmodule

// File: doc/msi_sched.md
Name: msi_sched

Overview:
- Round-robin MSI scheduler in front of the PCIe core's cfg_interrupt handshake.
- Collects rising-edge interrupt events from up to 32 user sources into a pending register; per-vector masking; coalescing of repeated events.
- Issues one MSI at a time with the vector number on cfg_interrupt_di, and enforces a programmable hold-off gap between MSIs.
- Sits between the application interrupt sources and the endpoint core's configuration interrupt port.

Parameters:
- C_INT_NUM, 4, number of interrupt sources (1..32).
- C_VEC_BASE, 0, offset added to the source index to form the MSI vector (C_VEC_BASE + C_INT_NUM - 1 must be <= 255).
- C_HOLD_W, 16, width of the hold-off counter and of holdoff_cycles.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- int_src  in  C_INT_NUM  level interrupt sources; a 0->1 transition is an event.
- int_mask  in  C_INT_NUM  1 = vector masked; its pending bit is held, not issued.
- msi_enable  in  1  MSI enable from config space; 0 blocks new issue.
- holdoff_cycles  in  C_HOLD_W  minimum idle cycles after each accepted MSI.
- cfg_interrupt_rdy_n  in  1  core accept, active-low.
- cfg_interrupt_n  out  1  MSI request, active-low.
- cfg_interrupt_assert_n  out  1  constant 0 (MSI mode).
- cfg_interrupt_di  out  8  MSI vector number.
- int_pending  out  C_INT_NUM  current pending register (status).

Behaviour:
- Reset values (rst=0): cfg_interrupt_n=1, cfg_interrupt_di=0, pending=0, int_src_d=0, hold counter=0, last_grant=C_INT_NUM-1 (vector 0 has first priority), state=IDLE.
- Because int_src_d resets to 0, a source held high when reset is released produces one event.
- Edge detect: evt = int_src & ~int_src_d; int_src_d registered every cycle.
- Pending update per bit: set on evt[i]; cleared on acceptance of vector i.
- If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
- An event on a bit that is already pending is coalesced: no second MSI.
- eligible = pending & ~int_mask, considered only when msi_enable=1.
- FSM states: IDLE, ARB, REQ, HOLD.
  - IDLE -> ARB when eligible != 0.
  - ARB: round-robin pick of the first eligible index after last_grant, wrapping from C_INT_NUM-1 to 0. Register sel. Register cfg_interrupt_di = C_VEC_BASE + sel, zero-extended to 8 bits. Go to REQ.
  - If eligible becomes 0 while in ARB (mask or disable changed), return to IDLE with no request.
  - REQ: cfg_interrupt_n=0 (registered, asserted on the first cycle of REQ). cfg_interrupt_di stays stable.
  - REQ exit, on the cycle cfg_interrupt_rdy_n=0: clear pending[sel], set last_grant=sel, cfg_interrupt_n=1 next cycle, load hold counter = holdoff_cycles. Next state is HOLD if holdoff_cycles != 0, else IDLE.
  - A mask or msi_enable change during REQ does not withdraw the request; the handshake always completes.
  - HOLD: decrement the counter each cycle; go to IDLE in the cycle it reaches 0. Events are still collected during HOLD.
- Latency: first cycle int_src high = cycle 0. Pending set at cycle 1, ARB at cycle 2, cfg_interrupt_n=0 at cycle 3 (idle, unmasked, enabled, no hold-off).
- Back-to-back throughput: with holdoff_cycles=0, IDLE->ARB->REQ gives at least 3 cycles between requests.
- Reset asserted mid-REQ: cfg_interrupt_n=1 on the following cycle and all pending is discarded.
- cfg_interrupt_rdy_n low outside REQ is ignored.

Optional Feature:
- Macro: MSI_SCHED_STATS_EN.
- Defined: adds outputs msi_sent_cnt[31:0] and msi_coal_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - msi_sent_cnt increments on each accepted MSI.
  - msi_coal_cnt increments by 1 in any cycle where at least one evt bit hits an already-pending bit.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package msi_sched_pkg: FSM state encoding (one-hot, 4 bits), vector width constant (8), maximum source count (32).
- One sub-module, rr_pick: combinational round-robin priority picker (request vector and last_grant in; index and valid out), parameterised by C_INT_NUM.
- Pending register, FSM and hold counter stay in the top level.

Test Plan:
- Single event: C_INT_NUM=4, int_src[2] rises at cycle 0, rdy_n low at cycle 5 -> cfg_interrupt_n=0 in cycles 3..5, di=0x02, pending returns to 0 at cycle 6.
- Round-robin: sources 0,1,3 rise together, holdoff=0, immediate rdy -> di sequence 0x00, 0x01, 0x03; another burst of 0 and 3 -> 0x00, 0x03 (resumes after last_grant=3).
- Mask/coalesce: mask[1]=1, int_src[1] pulses 3 times -> no MSI, pending[1]=1. Clear mask -> exactly one MSI, di=0x01; with stats defined, msi_coal_cnt=2.
- Hold-off: holdoff_cycles=10, two sources pending -> second cfg_interrupt_n falling edge is 13 cycles after first acceptance (10 HOLD + ARB + IDLE + REQ entry).
- Disable mid-REQ: msi_enable drops while cfg_interrupt_n=0 -> request held until rdy_n=0, then no further MSI while disabled; pending bits retained.
- Reset mid-REQ: rst=0 during REQ -> cfg_interrupt_n=1 next cycle, int_pending=0, di=0. Sources held high at release -> one MSI each, starting at vector 0.
